tank_model: RTL and testbench

TANK_MODEL -- requirements
Module: tank_model

---
 rtl/tank_model.sv | 91 +++++++++
 tb/tb_tank_model.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tank_model.sv
// Water tank: integrates pump inflow and valve drain each clock, clips at 0 and CAPACITY,
// keeps sticky overflow/dry flags and registered level sensors I and S.
module tank_model #(
   parameter int WIDTH      = 8,
   parameter int CAPACITY   = 200,
   parameter int LOW_MARK   = 40,
   parameter int HIGH_MARK  = 160,
   parameter int FILL1      = 2,
   parameter int FILL2      = 2,
   parameter int DRAIN      = 1,
   parameter int INIT_LEVEL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             B1,
   input  logic             B2,
   input  logic             consume,
   input  logic             clr_flags,
   output logic             I,
   output logic             S,
   output logic [WIDTH-1:0] level,
   output logic             overflow,
   output logic             dry
);

   localparam int NW = WIDTH + 2;
   localparam logic signed [NW-1:0] CAP_S = NW'(CAPACITY);

   typedef enum logic [1:0] {EMPTY, MID, FULL} phase_t;

   phase_t                 phase_reg, phase_next;
   logic [WIDTH-1:0]       level_reg, level_next;
   logic                   overflow_reg, overflow_next;
   logic                   dry_reg, dry_next;
   logic signed [NW-1:0]   net;

   // Two guard bits keep the sum of all simultaneous contributions exact.
   always_comb begin
      net = $signed({2'b00, level_reg});
      if (B1)      net = net + NW'(FILL1);
      if (B2)      net = net + NW'(FILL2);
      if (consume) net = net - NW'(DRAIN);
   end

   // A set on this edge overrides a simultaneous clear.
   always_comb begin
      level_next    = net[WIDTH-1:0];
      overflow_next = overflow_reg & ~clr_flags;
      dry_next      = dry_reg & ~clr_flags;
      if (net[NW-1]) begin
         level_next = '0;
         dry_next   = 1'b1;
      end else if (net > CAP_S) begin
         level_next    = WIDTH'(CAPACITY);
         overflow_next = 1'b1;
      end
   end

   // Phase is classified from the pre-edge level, so the sensors lag level by one cycle.
   always_comb begin
      if (level_reg >= WIDTH'(HIGH_MARK))
         phase_next = FULL;
      else if (level_reg >= WIDTH'(LOW_MARK))
         phase_next = MID;
      else
         phase_next = EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_reg    <= EMPTY;
         level_reg    <= WIDTH'(INIT_LEVEL);
         overflow_reg <= 1'b0;
         dry_reg      <= 1'b0;
      end else begin
         phase_reg    <= phase_next;
         level_reg    <= level_next;
         overflow_reg <= overflow_next;
         dry_reg      <= dry_next;
      end
   end

   always_comb begin
      I        = (phase_reg != EMPTY);
      S        = (phase_reg == FULL);
      level    = level_reg;
      overflow = overflow_reg;
      dry      = dry_reg;
   end

endmodule

// File: tb/tb_tank_model.sv
// Self-checking bench for tank_model: directed table, corner sequences, randomized run
// against an integer reference model, and a small-mark instance for the EMPTY-to-FULL jump.
module tb_tank_model;

   localparam int CAP  = 200;
   localparam int LOWM = 40;
   localparam int HIGHM = 160;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       b1 = 1'b0, b2 = 1'b0, cons = 1'b0, clr = 1'b0;
   logic       sen_i, sen_s, ovf, dry_f;
   logic [7:0] lvl;
   logic       p1 = 1'b0, p2 = 1'b0;
   logic       sen_i2, sen_s2, ovf2, dry_f2;
   logic [7:0] lvl2;

   int vectors = 0;
   int miscompares = 0;

   int m_level, m_i, m_s, m_ovf, m_dry;

   typedef struct {
      logic a1, a2, ac, acl;
      int   e_level;
      logic e_i, e_s, e_ovf, e_dry;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   tank_model dut (
      .clk(clk), .reset(reset), .B1(b1), .B2(b2), .consume(cons), .clr_flags(clr),
      .I(sen_i), .S(sen_s), .level(lvl), .overflow(ovf), .dry(dry_f)
   );

   tank_model #(.LOW_MARK(4), .HIGH_MARK(6), .FILL1(4), .FILL2(4)) dut2 (
      .clk(clk), .reset(reset), .B1(p1), .B2(p2), .consume(1'b0), .clr_flags(1'b0),
      .I(sen_i2), .S(sen_s2), .level(lvl2), .overflow(ovf2), .dry(dry_f2)
   );

   task automatic cmp(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 0; m_i = 0; m_s = 0; m_ovf = 0; m_dry = 0;
   endtask

   // Reference: sensors see the old level; level follows the clipped arithmetic sum.
   task automatic model_step(input logic a1, a2, ac, acl);
      int n;
      m_i = (m_level >= LOWM) ? 1 : 0;
      m_s = (m_level >= HIGHM) ? 1 : 0;
      n = m_level + (a1 ? 2 : 0) + (a2 ? 2 : 0) - (ac ? 1 : 0);
      if (acl) begin m_ovf = 0; m_dry = 0; end
      if (n > CAP) begin m_level = CAP; m_ovf = 1; end
      else if (n < 0) begin m_level = 0; m_dry = 1; end
      else m_level = n;
   endtask

   task automatic check_model(input string tag);
      int act, exp;
      act = {lvl, sen_i, sen_s, ovf, dry_f};
      exp = {m_level[7:0], m_i[0], m_s[0], m_ovf[0], m_dry[0]};
      vectors++;
      if (act !== exp || (sen_s && !sen_i)) begin
         miscompares++;
         $display("FAIL %s: got level=%0d I=%b S=%b ovf=%b dry=%b, expected level=%0d I=%0d S=%0d ovf=%0d dry=%0d",
                  tag, lvl, sen_i, sen_s, ovf, dry_f, m_level, m_i, m_s, m_ovf, m_dry);
      end else begin
         $display("ok %s: level=%0d I=%b S=%b ovf=%b dry=%b", tag, lvl, sen_i, sen_s, ovf, dry_f);
      end
   endtask

   task automatic step(input logic a1, a2, ac, acl, input string tag);
      b1 = a1; b2 = a2; cons = ac; clr = acl;
      @(posedge clk);
      model_step(a1, a2, ac, acl);
      #1;
      b1 = 1'b0; b2 = 1'b0; cons = 1'b0; clr = 1'b0;
      check_model(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0,  4, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0,  7, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1,  9, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0,  9, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset state, then inputs ignored while reset is held.
      #2;
      cmp("reset_state", {lvl, sen_i, sen_s, ovf, dry_f}, 0);
      b1 = 1'b1; b2 = 1'b1; cons = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      cmp("reset_ignores_inputs", {lvl, sen_i, sen_s, ovf, dry_f}, 0);
      b1 = 1'b0; b2 = 1'b0; cons = 1'b0;
      reset = 1'b0;
      model_reset();

      for (int k = 0; k < 7; k++) begin
         step(tbl[k].a1, tbl[k].a2, tbl[k].ac, tbl[k].acl, $sformatf("table%0d", k));
         cmp($sformatf("table%0d_exp", k), {lvl, sen_i, sen_s, ovf, dry_f},
             {tbl[k].e_level[7:0], tbl[k].e_i, tbl[k].e_s, tbl[k].e_ovf, tbl[k].e_dry});
      end

      // Single pump ramp.
      do_reset();
      for (int n = 1; n <= 79; n++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("ramp1_e%0d", n));
         if (n == 20) cmp("ramp1_level_e20", lvl, 40);
         if (n == 20) cmp("ramp1_I_e20", sen_i, 0);
         if (n == 21) cmp("ramp1_I_e21", sen_i, 1);
         if (n == 79) cmp("ramp1_S_e79", sen_s, 0);
      end

      // Both pumps to the top and into overflow.
      do_reset();
      for (int n = 1; n <= 53; n++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("ramp2_e%0d", n));
         if (n == 40) cmp("ramp2_level_e40", lvl, 160);
         if (n == 41) cmp("ramp2_S_e41", sen_s, 1);
         if (n == 50) cmp("ramp2_level_e50", lvl, 200);
         if (n == 52) cmp("ramp2_overflow", ovf, 1);
         if (n == 53) cmp("ramp2_hold_cap", lvl, 200);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1, "ovf_clear");
      cmp("ovf_cleared", ovf, 0);

      // Dry with clear colliding with a new set.
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0, "dry_set");
      cmp("dry_set_flag", dry_f, 1);
      step(1'b0, 1'b0, 1'b1, 1'b1, "dry_clr_vs_set");
      cmp("dry_set_wins", dry_f, 1);
      cmp("dry_level_zero", lvl, 0);

      // Balanced inflow and drain from level 3.
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b0, "to4");
      step(1'b0, 1'b0, 1'b1, 1'b0, "to3");
      for (int n = 1; n <= 10; n++) step(1'b1, 1'b0, 1'b1, 1'b0, $sformatf("bal_e%0d", n));
      cmp("bal_result", {lvl, sen_i, ovf, dry_f}, {8'd13, 1'b0, 1'b0, 1'b0});

      // Short async reset pulse between edges at level 120.
      do_reset();
      for (int n = 1; n <= 30; n++) step(1'b1, 1'b1, 1'b0, 1'b0, $sformatf("pre_pulse_e%0d", n));
      cmp("pulse_pre_level", lvl, 120);
      step(1'b0, 1'b0, 1'b0, 1'b0, "pulse_idle");
      b1 = 1'b1; b2 = 1'b1;
      #3 reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      cmp("pulse_async_clear", {lvl, sen_i, sen_s}, 0);
      b1 = 1'b0; b2 = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, "post_pulse");

      // Randomized run with a varying pump duty per block.
      do_reset();
      for (int blk = 0; blk < 12; blk++) begin
         int pump_p;
         pump_p = $urandom_range(0, 3);
         for (int n = 0; n < 50; n++) begin
            logic r1, r2, rc, rk;
            r1 = ($urandom_range(0, 3) < pump_p);
            r2 = ($urandom_range(0, 3) < pump_p);
            rc = ($urandom_range(0, 3) != 0);
            rk = ($urandom_range(0, 7) == 0);
            step(r1, r2, rc, rk, $sformatf("rand_b%0d_%0d", blk, n));
         end
      end

      // Narrow marks: one cycle jumps EMPTY straight to FULL.
      do_reset();
      p1 = 1'b1; p2 = 1'b1;
      @(posedge clk); #1;
      cmp("jump_level_e1", lvl2, 8);
      cmp("jump_IS_e1", {sen_i2, sen_s2}, 0);
      @(posedge clk); #1;
      cmp("jump_IS_e2", {sen_i2, sen_s2}, 3);
      p1 = 1'b0; p2 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
